// File: rtl/btn_debounce_counter.sv
// Two-button synchroniser/debouncer with press/release strobes and an up/down press counter on active-low LEDs.
// Optional auto-repeat of press strobes while held: define BTN_AUTO_REPEAT_EN.
module btn_debounce_counter #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned CNT_W           = 19
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 13500000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn1,
  input  logic               btn2,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [5:0]         led
);

  localparam int unsigned LED_W = 6;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
`endif

  logic [NUM_BTN-1:0] raw_c;
  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] pressed_c;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0]   db_cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   db_cnt_d [NUM_BTN];
  logic [LED_W-1:0]   count_q, count_d;
  logic [LED_W-1:0]   led_q;
`ifdef BTN_AUTO_REPEAT_EN
  logic [REP_W-1:0]   rpt_q [NUM_BTN];
  logic [REP_W-1:0]   rpt_d [NUM_BTN];
`endif

  assign raw_c     = NUM_BTN'({btn2, btn1});
  assign pressed_c = ~sync2_q;

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign led           = led_q;

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (pressed_c[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_d[i]  = '0;
        level_d[i]   = pressed_c[i];
        press_d[i]   = pressed_c[i];
        release_d[i] = ~pressed_c[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
`ifdef BTN_AUTO_REPEAT_EN
    // Repeat strobes only while the level is steadily high, so they never coincide with a release
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      rpt_d[i] = rpt_q[i];
      if (!level_q[i] || (level_d[i] != level_q[i])) begin
        rpt_d[i] = '0;
      end else if (rpt_q[i] == REP_W'(REPEAT_CYCLES - 1)) begin
        rpt_d[i]   = '0;
        press_d[i] = 1'b1;
      end else begin
        rpt_d[i] = rpt_q[i] + REP_W'(1);
      end
    end
`endif
  end

  // Up on button 0, down on button 1, hold when both strobe together
  always_comb begin
    count_d = count_q;
    if (press_q[0] && !press_q[1]) begin
      count_d = count_q + LED_W'(1);
    end else if (press_q[1] && !press_q[0]) begin
      count_d = count_q - LED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      count_q   <= '0;
      led_q     <= '1;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        db_cnt_q[i] <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q[i]    <= '0;
`endif
      end
    end else begin
      sync1_q   <= raw_c;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
      led_q     <= ~count_d;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q[i]    <= rpt_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Scoreboard bench for btn_debounce_counter with DEBOUNCE_CYCLES=8 (REPEAT_CYCLES=16 when BTN_AUTO_REPEAT_EN).
module tb_btn_debounce_counter;

  typedef struct {
    logic [1:0] pr;
    logic [1:0] rl;
    int         cyc;
    logic [5:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn1 = 1'b1;
  logic       btn2 = 1'b1;
  logic [1:0] btn_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [5:0] led;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       sb_q[$];
  logic [5:0] cnt_m = '0;
  logic       led_pending = 1'b0;
  logic [5:0] led_exp = '0;

  btn_debounce_counter #(
    .NUM_BTN(2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn1(btn1),
    .btn2(btn2),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [1:0] pr, input logic [1:0] rl, input int at);
    exp_t e;
    e.pr  = pr;
    e.rl  = rl;
    e.cyc = at;
    e.led = ~cnt_m;
    sb_q.push_back(e);
  endtask

  // Monitor: any strobe pops one expectation; the LED is checked on the following cycle
  always @(negedge clk) begin
    if (rst) begin
      led_pending = 1'b0;
    end else begin
      if (led_pending) begin
        chk("led_after_pulse", int'(led), int'(led_exp));
        led_pending = 1'b0;
      end
      if ((press_pulse | release_pulse) != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", int'({press_pulse, release_pulse}), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("pulse_vector", int'({press_pulse, release_pulse}), int'({e.pr, e.rl}));
          chk("pulse_cycle", cyc, e.cyc);
          led_pending = 1'b1;
          led_exp     = e.led;
        end
      end
    end
  end

  task automatic drive(input logic [1:0] m, input logic v);
    if (m[0]) btn1 = v;
    if (m[1]) btn2 = v;
  endtask

  task automatic model_press(input logic [1:0] m);
    if (m == 2'b01) cnt_m = cnt_m + 6'd1;
    else if (m == 2'b10) cnt_m = cnt_m - 6'd1;
  endtask

  task automatic press_release(input logic [1:0] m);
    @(negedge clk);
    drive(m, 1'b0);
    model_press(m);
    push(m, 2'b00, cyc + 10);
    repeat (12) @(negedge clk);
    drive(m, 1'b1);
    push(2'b00, m, cyc + 10);
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cnt_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and idle quiet period
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_led", int'(led), 63);
    chk("reset_pulses", int'({press_pulse, release_pulse}), 0);
    repeat (50) @(negedge clk);
    chk("idle_led", int'(led), 63);

    // Clean press/release of btn1: count 1
    press_release(2'b01);
    chk("level_after_release", int'(btn_level), 0);

    // Bounce on btn1 then steady low: count 2
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      btn1 = 1'b0;
      repeat (3) @(negedge clk);
      btn1 = 1'b1;
      @(negedge clk);
    end
    btn1 = 1'b0;
    model_press(2'b01);
    push(2'b01, 2'b00, cyc + 10);
    repeat (12) @(negedge clk);
    chk("level_held", int'(btn_level), 1);
    btn1 = 1'b1;
    push(2'b00, 2'b01, cyc + 10);
    repeat (14) @(negedge clk);

    // Down to 0 then wrap to 63, then back up to 0
    press_release(2'b10);
    press_release(2'b10);
    chk("count_zero_led", int'(led), 63);
    press_release(2'b10);
    chk("wrap_down_led", int'(led), 0);
    press_release(2'b01);
    chk("wrap_up_led", int'(led), 63);

    // Both buttons together: count unchanged
    press_release(2'b11);
    chk("both_led", int'(led), 63);

    // Reset while btn1 is mid-debounce and held
    @(negedge clk);
    btn1 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_level", int'(btn_level), 0);
    chk("rst_mid_led", int'(led), 63);
    chk("rst_mid_pulses", int'({press_pulse, release_pulse}), 0);
    cnt_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_press(2'b01);
    push(2'b01, 2'b00, cyc + 10);
    repeat (12) @(negedge clk);
    btn1 = 1'b1;
    push(2'b00, 2'b01, cyc + 10);
    repeat (14) @(negedge clk);
    chk("post_rst_led", int'(led), 62);

`ifdef BTN_AUTO_REPEAT_EN
    // Held 50 cycles: initial press plus three repeats
    do_reset();
    @(negedge clk);
    btn1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model_press(2'b01);
      push(2'b01, 2'b00, cyc + 10 + 16 * k);
    end
    repeat (50) @(negedge clk);
    btn1 = 1'b1;
    push(2'b00, 2'b01, cyc + 10);
    repeat (14) @(negedge clk);
    chk("repeat_led", int'(led), 59);
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/btn_debounce_counter.md
Name: btn_debounce_counter

Overview:
- Input-side conditioner for the board push-buttons, which are raw, bouncy and active-low.
- Per button: synchronises the raw input, debounces it with a stability counter, and emits a clean level plus one-cycle press/release pulses.
- Includes a small up/down press counter shown on the active-low 6-LED bank.
- Sits between the board pins and downstream gate/logic blocks. It replaces direct use of raw btn inputs.

Parameters:
- NUM_BTN, 2, number of buttons conditioned; fixed at 2 for counter logic (btn index 0 = up, 1 = down).
- DEBOUNCE_CYCLES, 270000, consecutive stable synchronised cycles required before accepting a change (10 ms at 27 MHz); must be >= 2.
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn1  input  1  raw button 0, active-low (0 = pressed).
- btn2  input  1  raw button 1, active-low (0 = pressed).
- btn_level  output  2  debounced state, active-high (1 = pressed); bit0 = btn1, bit1 = btn2.
- press_pulse  output  2  one-cycle strobe on debounced press.
- release_pulse  output  2  one-cycle strobe on debounced release.
- led  output  6  active-low display of press count (led = ~count).

Behaviour:
- Reset (async assert, sync release): sync flops = 1 (released), btn_level = 0, counters = 0, press_pulse = release_pulse = 0, count = 0, led = 6'b111111.
- Synchroniser: two flops per button; s = ~sync2 (pressed = 1).
- Debounce per button, each clock:
  - if s == btn_level: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: btn_level <= s, counter <= 0.
  - else: counter <= counter + 1.
- A single-cycle glitch back to the stable value restarts the count from 0.
- Latency: raw edge -> btn_level change = 2 (sync) + DEBOUNCE_CYCLES clock edges.
- Pulses are registered at the same edge btn_level changes:
  - press_pulse[i] = 1 for exactly one cycle on a 0->1 change.
  - release_pulse[i] = 1 for exactly one cycle on a 1->0 change.
  - Press and release pulses are never simultaneous for the same button.
- Press counter (6-bit, registered one cycle after the pulse):
  - press_pulse[0] only -> count + 1, wrapping 63 -> 0.
  - press_pulse[1] only -> count - 1, wrapping 0 -> 63.
  - Both in the same cycle -> unchanged.
  - Releases have no effect.
- led = ~count, registered output.
- Reset mid-debounce: counter is discarded, and btn_level returns to 0 even if the button is held. A button held through reset produces a press after 2 + DEBOUNCE_CYCLES cycles following reset release.
- Buttons are fully independent apart from the shared press counter.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - Adds parameter REPEAT_CYCLES (default 13500000, 0.5 s).
  - While btn_level[i] = 1, a per-button repeat counter runs. Each time it reaches REPEAT_CYCLES-1, press_pulse[i] fires one extra cycle and the counter clears.
  - The counter clears on release and on the initial press.
  - Repeated pulses drive the press counter identically to real presses.
- Undefined: no repeat logic; exactly one press_pulse per debounced press.

Test Plan (sim with DEBOUNCE_CYCLES=8):
- Reset, buttons high -> btn_level=00, led=111111, no pulses over 50 cycles.
- btn1 low and held -> btn_level[0] rises exactly 10 cycles after the edge; press_pulse[0] high 1 cycle; next cycle led=111110 (count=1).
- btn1 bounce: low 3 cycles, high 1, low 3, high, repeated 5 times, then steady low -> no pulse during bounce; single press 10 cycles after the final steady edge.
- count=0, press btn2 -> led=000000 (count=63); then press btn1 -> led=111111 (wrap back to 0).
- Both buttons pressed on the same cycle -> press_pulse=11 in one cycle; count unchanged.
- Hold btn1, assert rst mid-count (cycle 5 of 8) -> outputs reset immediately; after release, press_pulse[0] fires 10 cycles later. With BTN_AUTO_REPEAT_EN (REPEAT_CYCLES=16) holding 50 cycles -> 1 + 3 press pulses, count=4.
